// File: rtl/up5bit_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : up5bit_counter_pkg
// Description : Shared types and helpers for the up-counter monitor.
//               Holds the monitor state encoding, the default observed-count
//               width and a modulo-2^width increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package up5bit_counter_pkg;

    // Default width of the observed counter bus.
    localparam int c_default_width = 5;

    // Width of the consecutive-hit / consecutive-miss run counters.
    // Thresholds are limited to 1..15, so four bits always suffice.
    localparam int c_run_w = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // Increment modulo 2^width. The result is masked so that callers
    // truncating to 'width' bits, or not, see identical wrap behaviour.
    function automatic logic [31:0] inc_mod(input logic [31:0] value,
                                            input int unsigned width);
        logic [32:0] w_mask;
        logic [32:0] w_sum;
        w_mask = (33'd1 << width) - 33'd1;
        w_sum  = {1'b0, value} + 33'd1;
        return 32'(w_sum & w_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/up5bit_counter_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//               Ports: clk   - clock
//                      reset - synchronous active-high reset
//                      clr   - synchronous clear, wins over inc
//                      inc   - increment request (ignored at all-ones)
//                      q     - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] c_max = {W{1'b1}};

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != c_max)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/up5bit_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module      : up5bit_counter_monitor
// Description : Receive-side checker for a free-running up-counter bus.
//               Acquires lock on the incoming sequence, then tracks it with
//               a flywheel prediction, flagging every non-increment step and
//               keeping saturating match/error statistics.
//               Ports: clk         - clock
//                      reset       - synchronous active-high reset
//                      cnt_in      - observed counter value
//                      sample_en   - cnt_in valid this cycle
//                      clr_stats   - clear err_count / match_count
//                      locked      - monitor is locked
//                      err_pulse   - one-cycle mismatch strobe (locked only)
//                      expected    - prediction for the next sample
//                      err_count   - saturating mismatch count
//                      match_count - saturating match count
// Revision    : 1.0 - initial release
// ============================================================================
module up5bit_counter_monitor
    import up5bit_counter_pkg::*;
#(
    parameter int WIDTH       = c_default_width,
    parameter int LOCK_THRESH = 2,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 8,
    parameter int MATCH_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic               sample_en,
    input  logic               clr_stats,
    output logic               locked,
    output logic               err_pulse,
    output logic [WIDTH-1:0]   expected,
    output logic [ERR_W-1:0]   err_count,
    output logic [MATCH_W-1:0] match_count
);

    mon_state_t         r_state;
    logic               r_locked;
    logic               r_err_pulse;
    logic [WIDTH-1:0]   r_expected;
    logic [c_run_w-1:0] r_good_run;
    logic [c_run_w-1:0] r_bad_run;

    logic [WIDTH-1:0]   w_cnt_inc;
    logic [WIDTH-1:0]   w_exp_inc;
    logic               w_match;
    logic               w_lock_done;
    logic               w_loss;
    logic               w_err_inc;
    logic               w_match_inc;

    assign w_cnt_inc   = WIDTH'(inc_mod(32'(cnt_in), WIDTH));
    assign w_exp_inc   = WIDTH'(inc_mod(32'(r_expected), WIDTH));
    assign w_match     = (cnt_in == r_expected);
    // Thresholds compare against the run count *including* this sample.
    assign w_lock_done = ((r_good_run + c_run_w'(1)) == c_run_w'(LOCK_THRESH));
    assign w_loss      = ((r_bad_run + c_run_w'(1)) == c_run_w'(LOSS_THRESH));

    // Statistics only move on samples taken while locked.
    assign w_err_inc   = sample_en && (r_state == LOCKED) && !w_match;
    assign w_match_inc = sample_en && (r_state == LOCKED) &&  w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_expected  <= '0;
            r_good_run  <= '0;
            r_bad_run   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (sample_en) begin
                case (r_state)
                    IDLE: begin
                        r_expected <= w_cnt_inc;
                        r_good_run <= '0;
                        r_state    <= ACQ;
                    end
                    ACQ: begin
                        r_expected <= w_cnt_inc;
                        if (w_match) begin
                            r_good_run <= r_good_run + c_run_w'(1);
                            if (w_lock_done) begin
                                r_state   <= LOCKED;
                                r_locked  <= 1'b1;
                                r_bad_run <= '0;
                            end
                        end else begin
                            // Silent resync: nothing is reported before lock.
                            r_good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_bad_run  <= '0;
                            r_expected <= w_cnt_inc;
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (w_loss) begin
                                r_state    <= ACQ;
                                r_locked   <= 1'b0;
                                r_expected <= w_cnt_inc;
                                r_good_run <= '0;
                                r_bad_run  <= '0;
                            end else begin
                                // Flywheel: keep predicting from our own
                                // sequence so a single glitch costs one error.
                                r_bad_run  <= r_bad_run + c_run_w'(1);
                                r_expected <= w_exp_inc;
                            end
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_stats),
        .inc   (w_err_inc),
        .q     (err_count)
    );

    sat_counter #(
        .W (MATCH_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_stats),
        .inc   (w_match_inc),
        .q     (match_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign expected  = r_expected;

endmodule
`default_nettype wire

// File: tb/tb_up5bit_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_up5bit_counter_monitor
// Description : Self-checking bench for up5bit_counter_monitor. A cycle-level
//               reference model tracks lock state, prediction and statistics
//               with integer arithmetic; every cycle the DUT outputs are
//               compared against it, and directed scenarios add literal
//               expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up5bit_counter_monitor;

    localparam int WIDTH       = 5;
    localparam int LOCK_THRESH = 2;
    localparam int LOSS_THRESH = 3;
    localparam int ERR_W       = 8;
    localparam int MATCH_W     = 16;
    localparam int MOD         = 1 << WIDTH;
    localparam int ERR_MAX     = (1 << ERR_W) - 1;
    localparam int MATCH_MAX   = (1 << MATCH_W) - 1;

    logic               clk;
    logic               reset;
    logic [WIDTH-1:0]   cnt_in;
    logic               sample_en;
    logic               clr_stats;
    logic               locked;
    logic               err_pulse;
    logic [WIDTH-1:0]   expected;
    logic [ERR_W-1:0]   err_count;
    logic [MATCH_W-1:0] match_count;

    int total = 0;
    int bad   = 0;

    up5bit_counter_monitor #(
        .WIDTH       (WIDTH),
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH),
        .ERR_W       (ERR_W),
        .MATCH_W     (MATCH_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_in      (cnt_in),
        .sample_en   (sample_en),
        .clr_stats   (clr_stats),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .expected    (expected),
        .err_count   (err_count),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = not yet seen a sample, 1 = hunting for lock, 2 = locked
    int m_mode    = 0;
    int m_pred    = 0;
    int m_hits    = 0;
    int m_misses  = 0;
    int m_errs    = 0;
    int m_matches = 0;
    bit m_pulse   = 1'b0;
    bit m_valid   = 1'b0;

    always @(posedge clk) begin
        int v;
        v = int'(cnt_in);
        if (reset) begin
            m_mode = 0; m_pred = 0; m_hits = 0; m_misses = 0;
            m_errs = 0; m_matches = 0; m_pulse = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_pulse = 1'b0;
            if (sample_en) begin
                if (m_mode == 0) begin
                    m_pred = (v + 1) % MOD;
                    m_hits = 0;
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (v == m_pred) begin
                        m_hits = m_hits + 1;
                        if (m_hits >= LOCK_THRESH) begin
                            m_mode = 2;
                            m_misses = 0;
                        end
                    end else begin
                        m_hits = 0;
                    end
                    m_pred = (v + 1) % MOD;
                end else begin
                    if (v == m_pred) begin
                        if (m_matches < MATCH_MAX) m_matches = m_matches + 1;
                        m_misses = 0;
                        m_pred = (v + 1) % MOD;
                    end else begin
                        m_pulse = 1'b1;
                        if (m_errs < ERR_MAX) m_errs = m_errs + 1;
                        m_misses = m_misses + 1;
                        if (m_misses >= LOSS_THRESH) begin
                            m_mode = 1;
                            m_hits = 0;
                            m_misses = 0;
                            m_pred = (v + 1) % MOD;
                        end else begin
                            m_pred = (m_pred + 1) % MOD;
                        end
                    end
                end
            end
            if (clr_stats) begin
                m_errs = 0;
                m_matches = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("locked",      locked,      (m_mode == 2) ? 1 : 0);
            chk("err_pulse",   err_pulse,   m_pulse);
            chk("expected",    expected,    m_pred);
            chk("err_count",   err_count,   m_errs);
            chk("match_count", match_count, m_matches);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input int v, input bit c);
        sample_en = s;
        cnt_in    = WIDTH'(v);
        clr_stats = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int e;
        reset = 1'b1; sample_en = 1'b0; cnt_in = '0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_locked",  locked,      0);
        chk("rst_pulse",   err_pulse,   0);
        chk("rst_expected", expected,   0);
        chk("rst_errc",    err_count,   0);
        chk("rst_matchc",  match_count, 0);
        reset = 1'b0;

        // Lock and wrap
        step(1, 28, 0);
        step(1, 29, 0);
        chk("lw_not_yet", locked, 0);
        step(1, 30, 0);
        chk("lw_locked", locked, 1);
        step(1, 31, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 2, 0);
        chk("lw_matchc", match_count, 4);
        chk("lw_errc",   err_count,   0);
        chk("lw_exp",    expected,    3);

        // Single glitch while locked
        for (int i = 3; i <= 7; i++) step(1, i, 0);
        step(1, 20, 0);
        chk("gl_pulse", err_pulse, 1);
        chk("gl_errc",  err_count, 1);
        chk("gl_exp",   expected,  9);
        step(1, 9, 0);
        chk("gl_pulse_off", err_pulse, 0);
        chk("gl_locked",    locked,    1);
        chk("gl_exp2",      expected,  10);

        // Loss of lock
        step(1, 0, 0);
        chk("ll_pulse1", err_pulse, 1);
        step(1, 0, 0);
        chk("ll_pulse2", err_pulse, 1);
        chk("ll_locked2", locked, 1);
        step(1, 0, 0);
        chk("ll_pulse3", err_pulse, 1);
        chk("ll_locked3", locked, 0);
        chk("ll_exp",   expected, 1);
        chk("ll_errc",  err_count, 4);
        step(1, 1, 0);
        chk("ll_acq", locked, 0);
        step(1, 2, 0);
        chk("ll_relock", locked, 1);
        chk("ll_exp2", expected, 3);

        // Counter reset mid-stream (stats cleared first, no sample)
        step(0, 0, 1);
        chk("cr_clr_errc", err_count, 0);
        chk("cr_clr_locked", locked, 1);
        for (int i = 3; i <= 13; i++) step(1, i, 0);
        step(1, 0, 0);
        chk("cr_pulse", err_pulse, 1);
        chk("cr_errc",  err_count, 1);
        chk("cr_exp",   expected,  15);
        step(1, 1, 0);
        chk("cr_exp2",  expected,  16);
        step(1, 2, 0);
        chk("cr_lost",  locked,    0);
        chk("cr_exp3",  expected,  3);
        step(1, 3, 0);
        step(1, 4, 0);
        chk("cr_relock", locked, 1);
        chk("cr_exp4", expected, 5);

        // Stats clear collision with a mismatching sample
        step(0, 0, 1);
        e = 5;
        for (int i = 0; i < 5; i++) begin
            step(1, (e + 16) % MOD, 0);
            step(1, (e + 1) % MOD, 0);
            e = (e + 2) % MOD;
        end
        chk("sc_errc5",   err_count,   5);
        chk("sc_matchc5", match_count, 5);
        chk("sc_exp",     expected,    15);
        step(1, 0, 1);
        chk("sc_pulse",  err_pulse,   1);
        chk("sc_errc",   err_count,   0);
        chk("sc_matchc", match_count, 0);
        chk("sc_locked", locked,      1);
        chk("sc_exp2",   expected,    16);

        // Gaps: sample_en low holds everything
        for (int i = 0; i < 10; i++) step(0, 7, 0);
        chk("gap_locked", locked,    1);
        chk("gap_pulse",  err_pulse, 0);
        chk("gap_exp",    expected,  16);
        step(1, 16, 0);
        chk("gap_matchc", match_count, 1);

        // Reset mid-stream, with a sample in the same cycle
        reset = 1'b1;
        step(1, 5, 1);
        reset = 1'b0;
        chk("mr_locked", locked,      0);
        chk("mr_exp",    expected,    0);
        chk("mr_matchc", match_count, 0);
        chk("mr_pulse",  err_pulse,   0);
        step(1, 9, 0);
        chk("mr_first_pulse", err_pulse, 0);
        chk("mr_first_exp",   expected,  10);

        // Error-counter saturation
        step(1, 10, 0);
        step(1, 11, 0);
        chk("sat_locked", locked, 1);
        e = 12;
        for (int i = 0; i < 260; i++) begin
            step(1, (e + 16) % MOD, 0);
            if (i == 259) begin
                chk("sat_pulse", err_pulse, 1);
                chk("sat_errc",  err_count, ERR_MAX);
            end
            step(1, (e + 1) % MOD, 0);
            e = (e + 2) % MOD;
        end
        chk("sat_errc_hold", err_count, ERR_MAX);
        chk("sat_matchc",    match_count, 260);

        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
